// File: rtl/ravenoc_pkg.sv
// Shared NoC constants and the arbiter state type used by the network-interface TX path.
package ravenoc_pkg;

  localparam int unsigned N_VIRT_CHN = 3;
  localparam int unsigned FLIT_WIDTH = 32;
  localparam int unsigned VC_WIDTH   = (N_VIRT_CHN > 1) ? $clog2(N_VIRT_CHN) : 1;

  typedef enum logic {
    IDLE,
    LOCKED
  } s_arb_state_t;

endpackage

// File: rtl/vc_credit_cnt.sv
// Per-VC downstream credit counter: starts full, saturates at CREDITS and flags overflow.
module vc_credit_cnt
  import ravenoc_pkg::*;
#(
  parameter int unsigned CREDITS = 4
) (
  input  logic clk,
  input  logic arst_n,
  input  logic dec_i,
  input  logic inc_i,
  output logic avail_o,
  output logic ovf_o
);

  localparam int unsigned CntW = $clog2(CREDITS + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_o = 1'b0;
    if (dec_i && !inc_i) begin
      cnt_d = cnt_q - CntW'(1);
    end else if (inc_i && !dec_i) begin
      if (cnt_q == CntW'(CREDITS)) begin
        ovf_o = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q <= CntW'(CREDITS);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign avail_o = (cnt_q != '0);

endmodule

// File: rtl/vc_tx_arbiter.sv
// Credit-aware wormhole VC arbiter for the NI transmit side.
// Define NI_RR_ARB_EN for round-robin arbitration; default is fixed priority (highest VC wins).
module vc_tx_arbiter
  import ravenoc_pkg::*;
#(
  parameter int unsigned N_VC    = N_VIRT_CHN,
  parameter int unsigned CREDITS = 4,
  parameter int unsigned FLIT_W  = FLIT_WIDTH
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic [N_VC-1:0]        req_valid_i,
  input  logic [N_VC-1:0]        req_head_i,
  input  logic [N_VC-1:0]        req_tail_i,
  input  logic [N_VC*FLIT_W-1:0] req_flit_i,
  output logic [N_VC-1:0]        req_ready_o,
  input  logic [N_VC-1:0]        credit_i,
  output logic                   out_valid_o,
  output logic [VC_WIDTH-1:0]    out_vc_o,
  output logic [FLIT_W-1:0]      out_flit_o,
  output logic                   busy_o,
  output logic                   err_o
);

  s_arb_state_t state_q, state_d;

  logic [VC_WIDTH-1:0] lock_vc_q, lock_vc_d;
  logic [VC_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [VC_WIDTH-1:0] win_idx, sel_idx;
  logic                win_found;
  int unsigned         cand;

  logic [N_VC-1:0] avail, ovf, elig, xfer;
  logic            xfer_any;

  logic                out_valid_q, out_valid_d;
  logic [VC_WIDTH-1:0] out_vc_q, out_vc_d;
  logic [FLIT_W-1:0]   out_flit_q, out_flit_d;
  logic                err_q, err_d;

  for (genvar i = 0; i < N_VC; i++) begin : g_credit
    vc_credit_cnt #(
      .CREDITS(CREDITS)
    ) u_cnt (
      .clk    (clk),
      .arst_n (arst_n),
      .dec_i  (xfer[i]),
      .inc_i  (credit_i[i]),
      .avail_o(avail[i]),
      .ovf_o  (ovf[i])
    );
  end

  // Candidates are visited from lowest to highest priority so the last hit wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    elig      = req_valid_i & req_head_i & avail;
    for (int unsigned k = 0; k < N_VC; k++) begin
`ifdef NI_RR_ARB_EN
      cand = (int'(rr_ptr_q) + N_VC - 1 - k) % N_VC;
`else
      // rr_ptr is pinned to 0 here, so this is a plain highest-index-first scan.
      cand = (int'(rr_ptr_q) + k) % N_VC;
`endif
      if (elig[cand]) begin
        win_found = 1'b1;
        win_idx   = VC_WIDTH'(cand);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    lock_vc_d   = lock_vc_q;
    rr_ptr_d    = rr_ptr_q;
    req_ready_o = '0;
    sel_idx     = lock_vc_q;

    unique case (state_q)
      IDLE: begin
        sel_idx = win_idx;
        if (win_found) begin
          req_ready_o[win_idx] = 1'b1;
        end
      end
      LOCKED: begin
        req_ready_o[lock_vc_q] = avail[lock_vc_q];
      end
      default: ;
    endcase

    xfer     = req_valid_i & req_ready_o;
    xfer_any = |xfer;

    unique case (state_q)
      IDLE: begin
        if (xfer_any) begin
`ifdef NI_RR_ARB_EN
          rr_ptr_d = (int'(win_idx) == N_VC - 1) ? '0 : win_idx + VC_WIDTH'(1);
`endif
          if (!req_tail_i[win_idx]) begin
            state_d   = LOCKED;
            lock_vc_d = win_idx;
          end
        end
      end
      LOCKED: begin
        if (xfer_any && req_tail_i[lock_vc_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = xfer_any;
    out_vc_d    = out_vc_q;
    out_flit_d  = out_flit_q;
    if (xfer_any) begin
      out_vc_d   = sel_idx;
      out_flit_d = req_flit_i[sel_idx*FLIT_W +: FLIT_W];
    end
  end

  assign err_d = err_q | (|ovf);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      lock_vc_q   <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_vc_q    <= '0;
      out_flit_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_vc_q   <= lock_vc_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_vc_q    <= out_vc_d;
      out_flit_q  <= out_flit_d;
      err_q       <= err_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_vc_o    = out_vc_q;
  assign out_flit_o  = out_flit_q;
  assign busy_o      = (state_q == LOCKED);
  assign err_o       = err_q;

endmodule
